// File: rtl/hazard_control_unit.sv
// Load-use / memory-wait / branch hazard controller for a 5-stage pipeline.
// Outputs are combinational so a load-use stall takes effect in the detecting cycle.
module hazard_control_unit #(
  parameter int REG_W    = 5,
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_RegisterRd,
  input  logic [REG_W-1:0] IFID_RegisterRs1,
  input  logic [REG_W-1:0] IFID_RegisterRs2,
  input  logic             IFID_UsesRs2,
  input  logic             EXMEM_MemRead,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             Bolha,
  output logic             IFID_Flush,
  output logic             Freeze,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {IDLE, LU_WAIT} state_t;

  localparam logic [2:0] LuInit = 3'(LU_STALL - 1);

  state_t           state;
  logic [2:0]       cnt;
  logic [CNT_W-1:0] stallCnt;
  logic             hit;
  logic             memWait;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign hit = IDEX_MemRead && (IDEX_RegisterRd != '0) &&
               ((IFID_RegisterRs1 == IDEX_RegisterRd) ||
                (IFID_UsesRs2 && (IFID_RegisterRs2 == IDEX_RegisterRd)));

  assign memWait     = EXMEM_MemRead && !mem_ready;
  assign stall_count = stallCnt;

  // Priority: reset, memory wait (freeze), taken branch (flush), load-use bubble.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    Bolha      = 1'b0;
    IFID_Flush = 1'b0;
    Freeze     = 1'b0;
    if (!rst) begin
      if (memWait) begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        Freeze    = 1'b1;
      end else if (branch_taken) begin
        IFID_Flush = 1'b1;
        Bolha      = 1'b1;
      end else if (state == LU_WAIT || hit) begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        Bolha     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      stallCnt <= '0;
    end else begin
      if (!PCWrite) stallCnt <= satInc(stallCnt);
      // A freeze holds the FSM so the remaining bubbles are still owed afterwards.
      if (!memWait) begin
        if (branch_taken) begin
          state <= IDLE;
          cnt   <= 3'd0;
        end else if (state == LU_WAIT) begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= IDLE;
        end else if (hit && LU_STALL > 1) begin
          state <= LU_WAIT;
          cnt   <= LuInit;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: three instances (LU_STALL=1, LU_STALL=3, CNT_W=2) share stimulus
// and are checked every cycle against a bubble-debt model plus literal expectations.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       memRead = 1'b0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic       usesRs2 = 1'b0;
  logic       exMemRead = 1'b0;
  logic       memReady = 1'b1;
  logic       brTaken = 1'b0;

  logic        pcw[3], ifw[3], bub[3], flu[3], frz[3];
  logic [15:0] sc0, sc1;
  logic [1:0]  sc2;

  int nVec = 0;
  int nErr = 0;

  int luOf[3]   = '{1, 3, 1};
  int satMax[3] = '{65535, 65535, 3};
  int pend[3];
  int mSc[3];

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_W(5), .LU_STALL(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .IDEX_MemRead(memRead), .IDEX_RegisterRd(rd),
    .IFID_RegisterRs1(rs1), .IFID_RegisterRs2(rs2), .IFID_UsesRs2(usesRs2),
    .EXMEM_MemRead(exMemRead), .mem_ready(memReady), .branch_taken(brTaken),
    .PCWrite(pcw[0]), .IFIDWrite(ifw[0]), .Bolha(bub[0]), .IFID_Flush(flu[0]),
    .Freeze(frz[0]), .stall_count(sc0));

  hazard_control_unit #(.REG_W(5), .LU_STALL(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .IDEX_MemRead(memRead), .IDEX_RegisterRd(rd),
    .IFID_RegisterRs1(rs1), .IFID_RegisterRs2(rs2), .IFID_UsesRs2(usesRs2),
    .EXMEM_MemRead(exMemRead), .mem_ready(memReady), .branch_taken(brTaken),
    .PCWrite(pcw[1]), .IFIDWrite(ifw[1]), .Bolha(bub[1]), .IFID_Flush(flu[1]),
    .Freeze(frz[1]), .stall_count(sc1));

  hazard_control_unit #(.REG_W(5), .LU_STALL(1), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .IDEX_MemRead(memRead), .IDEX_RegisterRd(rd),
    .IFID_RegisterRs1(rs1), .IFID_RegisterRs2(rs2), .IFID_UsesRs2(usesRs2),
    .EXMEM_MemRead(exMemRead), .mem_ready(memReady), .branch_taken(brTaken),
    .PCWrite(pcw[2]), .IFIDWrite(ifw[2]), .Bolha(bub[2]), .IFID_Flush(flu[2]),
    .Freeze(frz[2]), .stall_count(sc2));

  task automatic check(input string name, input int act, input int req);
    nVec++;
    if (act != req) begin
      nErr++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit mHit();
    return memRead && rd != 0 && (rs1 == rd || (usesRs2 && rs2 == rd));
  endfunction

  // Model: pend = bubbles still owed after the current one.
  function automatic void expOut(input int k, output bit p, output bit i,
                                 output bit b, output bit f, output bit z);
    bit mw;
    mw = exMemRead && !memReady;
    p = 1; i = 1; b = 0; f = 0; z = 0;
    if (rst) return;
    if (mw) begin
      p = 0; i = 0; z = 1;
    end else if (brTaken) begin
      f = 1; b = 1;
    end else if (pend[k] > 0 || mHit()) begin
      p = 0; i = 0; b = 1;
    end
  endfunction

  function automatic int actSc(input int k);
    if (k == 0) return int'(sc0);
    if (k == 1) return int'(sc1);
    return int'(sc2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        pend[k] <= 0;
        mSc[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit p, i, b, f, z;
        expOut(k, p, i, b, f, z);
        if (!p) mSc[k] <= (mSc[k] + 1 > satMax[k]) ? satMax[k] : mSc[k] + 1;
        if (!(exMemRead && !memReady)) begin
          if (brTaken) pend[k] <= 0;
          else if (pend[k] > 0) pend[k] <= pend[k] - 1;
          else if (mHit()) pend[k] <= luOf[k] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit p, i, b, f, z;
      expOut(k, p, i, b, f, z);
      check($sformatf("model_PCWrite[%0d]", k), int'(pcw[k]), int'(p));
      check($sformatf("model_IFIDWrite[%0d]", k), int'(ifw[k]), int'(i));
      check($sformatf("model_Bolha[%0d]", k), int'(bub[k]), int'(b));
      check($sformatf("model_IFID_Flush[%0d]", k), int'(flu[k]), int'(f));
      check($sformatf("model_Freeze[%0d]", k), int'(frz[k]), int'(z));
      check($sformatf("model_stall_count[%0d]", k), actSc(k), mSc[k]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    memRead = 0; rd = 0; rs1 = 0; rs2 = 0; usesRs2 = 0;
    exMemRead = 0; memReady = 1; brTaken = 0;
  endtask

  task automatic setHit();
    memRead = 1; rd = 5'd3; rs1 = 5'd3; rs2 = 5'd0; usesRs2 = 0;
  endtask

  task automatic pulseReset();
    clr();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  initial begin
    // Reset dominates an active hazard on the inputs.
    setHit();
    exMemRead = 1; memReady = 0;
    #2;
    check("rst_PCWrite", int'(pcw[1]), 1);
    check("rst_Bolha", int'(bub[1]), 0);
    check("rst_Freeze", int'(frz[1]), 0);
    check("rst_stall_count", int'(sc1), 0);
    cyc(); cyc();
    pulseReset();

    // Single-cycle load-use stall, then rs2 match gated by UsesRs2.
    setHit(); #1;
    check("lu1_PCWrite", int'(pcw[0]), 0);
    check("lu1_IFIDWrite", int'(ifw[0]), 0);
    check("lu1_Bolha", int'(bub[0]), 1);
    cyc();
    clr(); #1;
    check("lu1_release_PCWrite", int'(pcw[0]), 1);
    check("lu1_stall_count", int'(sc0), 1);
    memRead = 1; rd = 5'd3; rs1 = 5'd4; rs2 = 5'd3; usesRs2 = 0; #1;
    check("rs2_unused_Bolha", int'(bub[0]), 0);
    usesRs2 = 1; #1;
    check("rs2_used_Bolha", int'(bub[0]), 1);
    cyc();
    pulseReset();

    // Three-bubble load-use on the LU_STALL=3 instance.
    setHit(); #1;
    check("lu3_c0_Bolha", int'(bub[1]), 1);
    cyc(); clr(); #1;
    check("lu3_c1_Bolha", int'(bub[1]), 1);
    cyc();
    check("lu3_c2_Bolha", int'(bub[1]), 1);
    cyc();
    check("lu3_c3_Bolha", int'(bub[1]), 0);
    check("lu3_c3_PCWrite", int'(pcw[1]), 1);
    check("lu3_stall_count", int'(sc1), 3);
    cyc();
    pulseReset();

    // Two-cycle memory freeze inside LU_WAIT.
    setHit();
    cyc(); clr();
    exMemRead = 1; memReady = 0; #1;
    check("frz_c1_Freeze", int'(frz[1]), 1);
    check("frz_c1_Bolha", int'(bub[1]), 0);
    cyc();
    check("frz_c2_Freeze", int'(frz[1]), 1);
    cyc();
    exMemRead = 0; memReady = 1; #1;
    check("frz_after1_Bolha", int'(bub[1]), 1);
    cyc();
    check("frz_after2_Bolha", int'(bub[1]), 1);
    cyc();
    check("frz_done_Bolha", int'(bub[1]), 0);
    check("frz_stall_count", int'(sc1), 5);
    cyc();
    pulseReset();

    // Taken branch overrides a load-use hit.
    setHit(); brTaken = 1; #1;
    check("br_IFID_Flush", int'(flu[1]), 1);
    check("br_Bolha", int'(bub[1]), 1);
    check("br_PCWrite", int'(pcw[1]), 1);
    cyc(); clr(); #1;
    check("br_next_Bolha", int'(bub[1]), 0);
    check("br_stall_count", int'(sc1), 0);

    // Load into x0 never stalls.
    memRead = 1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; usesRs2 = 1; #1;
    check("x0_PCWrite", int'(pcw[0]), 1);
    check("x0_Bolha", int'(bub[1]), 0);
    cyc();
    pulseReset();

    // Five stall cycles saturate a 2-bit counter.
    setHit();
    repeat (5) cyc();
    clr(); #1;
    check("sat_stall_count", int'(sc2), 3);
    check("sat_ref_stall_count", int'(sc0), 5);
    cyc();
    pulseReset();

    // Asynchronous reset mid-LU_WAIT.
    setHit();
    cyc(); clr();
    #2 rst = 1;
    #1;
    check("arst_PCWrite", int'(pcw[1]), 1);
    check("arst_Bolha", int'(bub[1]), 0);
    check("arst_stall_count", int'(sc1), 0);
    rst = 0;
    cyc();
    check("arst_after_Bolha", int'(bub[1]), 0);
    check("arst_after_PCWrite", int'(pcw[1]), 1);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
